// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register with stall/flush and event counters
// Bubbles and invalid slots always carry BUBBLE_INST and an all-zero control bundle.
module pipe_stage_reg #(
  parameter int          PC_W        = 13,
  parameter int          DATA_W      = 64,
  parameter int          CTRL_W      = 6,
  parameter logic [31:0] BUBBLE_INST = 32'h00000013,
  parameter int          CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              validI,
  input  logic [PC_W-1:0]   pcI,
  input  logic [31:0]       instI,
  input  logic [CTRL_W-1:0] ctrlI,
  input  logic [DATA_W-1:0] dataI,
  output logic              validO,
  output logic [PC_W-1:0]   pcO,
  output logic [31:0]       instO,
  output logic [CTRL_W-1:0] ctrlO,
  output logic [DATA_W-1:0] dataO,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic stall_inc;
  logic flush_inc;

  // A flush overrides a stall, so a combined request counts only as a flush.
  assign stall_inc = stall && !flush;
  assign flush_inc = flush && (validO || validI);

  always_ff @(posedge CLK) begin
    if (RST) begin
      validO <= 1'b0;
      pcO    <= '0;
      instO  <= BUBBLE_INST;
      ctrlO  <= '0;
      dataO  <= '0;
    end else if (flush) begin
      validO <= 1'b0;
      instO  <= BUBBLE_INST;
      ctrlO  <= '0;
    end else if (!stall) begin
      validO <= validI;
      pcO    <= pcI;
      dataO  <= dataI;
      if (validI) begin
        instO <= instI;
        ctrlO <= ctrlI;
      end else begin
        instO <= BUBBLE_INST;
        ctrlO <= '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_inc && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || cnt_clr) begin
      flush_cnt <= '0;
    end else if (flush_inc && !(&flush_cnt)) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
// Runs with CNT_W=4 so counter saturation is reachable in a few cycles.
module tb_pipe_stage_reg;

  localparam int PC_W   = 13;
  localparam int DATA_W = 64;
  localparam int CTRL_W = 6;
  localparam int CNT_W  = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic              CLK = 1'b0;
  logic              RST, stall, flush, cnt_clr, validI;
  logic [PC_W-1:0]   pcI;
  logic [31:0]       instI;
  logic [CTRL_W-1:0] ctrlI;
  logic [DATA_W-1:0] dataI;
  logic              validO;
  logic [PC_W-1:0]   pcO;
  logic [31:0]       instO;
  logic [CTRL_W-1:0] ctrlO;
  logic [DATA_W-1:0] dataO;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_stage_reg #(
    .PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W),
    .BUBBLE_INST(NOP), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .validI(validI), .pcI(pcI), .instI(instI), .ctrlI(ctrlI), .dataI(dataI),
    .validO(validO), .pcO(pcO), .instO(instO), .ctrlO(ctrlO), .dataO(dataO),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [31:0] inst,
                       input logic [CTRL_W-1:0] ctrl, input logic [DATA_W-1:0] data);
    validI = v; pcI = pc; instI = inst; ctrlI = ctrl; dataI = data;
  endtask

  task automatic check_fields(input string tag, input logic v, input logic [PC_W-1:0] pc,
                              input logic [31:0] inst, input logic [CTRL_W-1:0] ctrl,
                              input logic [DATA_W-1:0] data);
    check({tag, ".valid"}, 64'(validO), 64'(v));
    check({tag, ".pc"},    64'(pcO),    64'(pc));
    check({tag, ".inst"},  64'(instO),  64'(inst));
    check({tag, ".ctrl"},  64'(ctrlO),  64'(ctrl));
    check({tag, ".data"},  dataO,       data);
  endtask

  task automatic check_cnts(input string tag, input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] f);
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(s));
    check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(f));
  endtask

  initial begin
    RST = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    @(negedge CLK);
    step();
    RST = 1'b0;
    check_fields("reset", 1'b0, 13'h000, NOP, 6'h00, 64'h0);
    check_cnts("reset", 4'h0, 4'h0);

    // 1: free-run load
    drive(1'b1, 13'h004, 32'h00500093, 6'h21, 64'hA5);
    step();
    check_fields("load", 1'b1, 13'h004, 32'h00500093, 6'h21, 64'hA5);

    // 2: stall hold while inputs change, then release
    drive(1'b1, 13'h008, 32'h00A00113, 6'h05, 64'h1234);
    step();
    check_fields("preload", 1'b1, 13'h008, 32'h00A00113, 6'h05, 64'h1234);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 13'(12 + 4 * i), 32'hDEAD0000 + 32'(i), 6'h3F, 64'hFFFF_0000 + 64'(i));
      step();
    end
    check_fields("stall_hold", 1'b1, 13'h008, 32'h00A00113, 6'h05, 64'h1234);
    check_cnts("stall_hold", 4'h3, 4'h0);
    stall = 1'b0;
    drive(1'b1, 13'h020, 32'h00C00193, 6'h11, 64'hBEEF);
    step();
    check_fields("release", 1'b1, 13'h020, 32'h00C00193, 6'h11, 64'hBEEF);
    check_cnts("release", 4'h3, 4'h0);

    // 3: flush together with stall
    flush = 1'b1; stall = 1'b1;
    drive(1'b1, 13'h024, 32'h01000213, 6'h22, 64'hCAFE);
    step();
    flush = 1'b0; stall = 1'b0;
    check_fields("flush_stall", 1'b0, 13'h020, NOP, 6'h00, 64'hBEEF);
    check_cnts("flush_stall", 4'h3, 4'h1);

    // 4: invalid slot is sanitised; flushing an empty slot is not counted
    drive(1'b0, 13'h030, 32'hFFFFFFFF, 6'h3F, 64'h77);
    step();
    check_fields("sanitise", 1'b0, 13'h030, NOP, 6'h00, 64'h77);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_fields("empty_flush", 1'b0, 13'h030, NOP, 6'h00, 64'h77);
    check_cnts("empty_flush", 4'h3, 4'h1);

    // 5: saturation then clear
    stall = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("sat_reach", 64'(stall_cnt), 64'hF);
    for (int i = 0; i < 8; i++) step();
    check("sat_hold", 64'(stall_cnt), 64'hF);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check_cnts("clr", 4'h0, 4'h0);
    check_fields("clr_fields", 1'b0, 13'h030, NOP, 6'h00, 64'h77);
    step();
    check("clr_next", 64'(stall_cnt), 64'h1);

    // 6: reset during stall with non-zero counters
    stall = 1'b0;
    drive(1'b1, 13'h040, 32'h00108093, 6'h2A, 64'h99);
    step();
    check_fields("pre_rst_load", 1'b1, 13'h040, 32'h00108093, 6'h2A, 64'h99);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b1, 13'h044, 32'h00208093, 6'h15, 64'h55);
    step();
    stall = 1'b1;
    step();
    check_cnts("pre_rst", 4'h2, 4'h1);
    RST = 1'b1;
    step();
    RST = 1'b0; stall = 1'b0;
    check_fields("mid_rst", 1'b0, 13'h000, NOP, 6'h00, 64'h0);
    check_cnts("mid_rst", 4'h0, 4'h0);
    drive(1'b1, 13'h050, 32'h00318193, 6'h09, 64'h0123_4567_89AB_CDEF);
    step();
    check_fields("post_rst", 1'b1, 13'h050, 32'h00318193, 6'h09, 64'h0123_4567_89AB_CDEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the RV32I core; the successor to the fixed-width stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries PC, instruction, a control bundle and a data payload.
- Adds a valid bit, stall (hold), flush (bubble insertion), synchronous reset and saturating stall/flush event counters for performance debug.
- One instance sits between each pair of pipeline stages and is driven by the hazard unit.

Parameters:
PC_W, 13, width of PC field
DATA_W, 64, width of data payload (e.g. result + store data)
CTRL_W, 6, width of control bundle; all-zero encodes "no side effect" (no reg write, no store, no load)
BUBBLE_INST, 32'h00000013, instruction word inserted for bubbles (addi x0,x0,0)
CNT_W, 16, width of each event counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
stall  in  1  hold all stage contents this cycle
flush  in  1  replace stage contents with a bubble this cycle
cnt_clr  in  1  synchronous clear of both event counters
validI  in  1  upstream instruction valid
pcI  in  PC_W  upstream PC
instI  in  32  upstream instruction
ctrlI  in  CTRL_W  upstream control bundle
dataI  in  DATA_W  upstream payload
validO  out  1  registered valid
pcO  out  PC_W  registered PC
instO  out  32  registered instruction
ctrlO  out  CTRL_W  registered control bundle
dataO  out  DATA_W  registered payload
stall_cnt  out  CNT_W  count of stall-hold cycles
flush_cnt  out  CNT_W  count of flushes that squashed a valid instruction

Behaviour:
- All state updates on the rising CLK edge. Latency is 1 cycle when not stalled. No combinational path from inputs to outputs.
- Per-cycle action priority: RST > flush > stall > load.
- RST:
  - validO=0, pcO=0, instO=BUBBLE_INST, ctrlO=0, dataO=0.
  - stall_cnt=0, flush_cnt=0.
  - Overrides every other input, including mid-stall or mid-flush.
- flush (RST=0):
  - validO=0, instO=BUBBLE_INST, ctrlO=0.
  - pcO and dataO hold their previous values.
  - stall is ignored this cycle. flush+stall together produces a bubble and does not increment stall_cnt.
- stall (RST=0, flush=0):
  - All five outputs hold.
  - Upstream inputs are ignored (upstream is held by the hazard unit).
- load (RST=0, flush=0, stall=0):
  - validO<=validI, pcO<=pcI, dataO<=dataI.
  - If validI=1: instO<=instI, ctrlO<=ctrlI.
  - If validI=0 (sanitise): instO<=BUBBLE_INST, ctrlO<=0, so an invalid slot can never cause side effects downstream.
- Invariant: validO=0 implies ctrlO=0 and instO=BUBBLE_INST at every cycle after reset.
- stall_cnt:
  - Increments by 1 in each cycle with RST=0, flush=0, stall=1, regardless of validO.
  - Saturates at 2^CNT_W-1 (no wrap).
- flush_cnt:
  - Increments by 1 in each cycle with RST=0, flush=1 and (validO=1 or validI=1), i.e. an actual instruction was squashed.
  - Saturates at 2^CNT_W-1.
- cnt_clr:
  - Clears both counters to 0. Takes precedence over an increment in the same cycle.
  - Does not affect pipeline fields.
- Counters are independent of each other; both may be non-zero, but they never both increment in the same cycle.

Test Plan:
1. Reset then free-run: after RST for 1 cycle, drive validI=1, pcI=13'h004, instI=32'h00500093, ctrlI=6'h21, dataI=64'hA5 -> next edge outputs equal inputs, validO=1. Before that edge, validO=0, instO=32'h00000013, ctrlO=0, counters 0.
2. Stall hold: load pc=13'h008, then stall=1 for 3 cycles while inputs change -> outputs stay pc=13'h008 with the original inst/ctrl/data; stall_cnt=3. On release, the next edge captures current inputs.
3. Flush vs stall: with validO=1, assert flush=1 and stall=1 together -> validO=0, ctrlO=0, instO=32'h00000013, pcO unchanged; flush_cnt=1, stall_cnt unchanged.
4. Invalid sanitise: drive validI=0, instI=32'hFFFFFFFF, ctrlI=6'h3F, no stall/flush -> validO=0, instO=32'h00000013, ctrlO=0, pcO/dataO captured. A later flush with validO=0 and validI=0 leaves flush_cnt unchanged.
5. Counter saturation and clear (CNT_W=4): stall for 20 cycles -> stall_cnt=4'hF and holds. Then assert cnt_clr together with stall -> stall_cnt=0 on that edge and 1 on the next stalled edge.
6. Reset mid-operation: assert RST during an active stall with counters non-zero -> all outputs return to reset values on that edge; the pipeline reloads normally on the next cycle after RST drops.
